// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: captures decoded fields,
// forwards MEM/WB results onto the operands and decodes the ALU operation code.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OPCODE_LENGTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [1:0]                id_alu_op,
  input  logic                      id_alu_src,
  input  logic [2:0]                id_funct3,
  input  logic                      id_funct7_b5,
  input  logic                      id_reg_write,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_imm
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE   = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_BLT   = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE   = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ   = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_UNSUP = OPCODE_LENGTH'(4'b1111);

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [1:0]                alu_op;
    logic                      alu_src;
    logic [2:0]                funct3;
    logic                      funct7_b5;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
  } id_ex_t;

  id_ex_t                  id_fields;
  id_ex_t                  ex_q;
  logic [DATA_WIDTH-1:0]   rs1_fwd;
  logic [DATA_WIDTH-1:0]   rs2_fwd;

  always_comb begin
    id_fields.valid     = id_valid;
    id_fields.reg_write = id_reg_write;
    id_fields.alu_op    = id_alu_op;
    id_fields.alu_src   = id_alu_src;
    id_fields.funct3    = id_funct3;
    id_fields.funct7_b5 = id_funct7_b5;
    id_fields.rs1_addr  = id_rs1_addr;
    id_fields.rs2_addr  = id_rs2_addr;
    id_fields.rd_addr   = id_rd_addr;
    id_fields.rs1_data  = id_rs1_data;
    id_fields.rs2_data  = id_rs2_data;
    id_fields.imm       = id_imm;
    id_fields.pc        = id_pc;
  end

  // An all-zero record is a bubble: invalid, alu_op 00, x0 addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= id_fields;
    end
  end

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs1_addr)) begin
      rs1_fwd = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs1_addr)) begin
      rs1_fwd = wb_result;
    end

    rs2_fwd = ex_q.rs2_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs2_addr)) begin
      rs2_fwd = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs2_addr)) begin
      rs2_fwd = wb_result;
    end
  end

  // Immediate-form arithmetic (ADDI) ignores bit 30, so SUB needs alu_src=0.
  always_comb begin
    Operation = OP_UNSUP;
    unique case (ex_q.alu_op)
      2'b00: Operation = OP_ADD;
      2'b01: begin
        case (ex_q.funct3)
          3'b000:  Operation = OP_BEQ;
          3'b001:  Operation = OP_BNE;
          3'b100:  Operation = OP_BLT;
          3'b101:  Operation = OP_BGE;
          default: Operation = OP_UNSUP;
        endcase
      end
      2'b10: begin
        case (ex_q.funct3)
          3'b000:  Operation = (!ex_q.alu_src && ex_q.funct7_b5) ? OP_SUB : OP_ADD;
          3'b100:  Operation = OP_XOR;
          3'b110:  Operation = OP_OR;
          3'b111:  Operation = OP_AND;
          default: Operation = OP_UNSUP;
        endcase
      end
      default: Operation = OP_UNSUP;
    endcase
  end

  assign SrcA          = rs1_fwd;
  assign SrcB          = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write & ex_q.valid;
  assign ex_rd         = ex_q.rd_addr;
  assign ex_pc         = ex_q.pc;
  assign ex_imm        = ex_q.imm;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the ID/EX register.
module tb_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 4;

  logic          clk;
  logic          reset;
  logic          stall, flush, id_valid;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [1:0]    id_alu_op;
  logic          id_alu_src, id_funct7_b5, id_reg_write;
  logic [2:0]    id_funct3;
  logic          mem_reg_write, wb_reg_write;
  logic [AW-1:0] mem_rd, wb_rd;
  logic [DW-1:0] mem_result, wb_result;
  logic [DW-1:0] SrcA, SrcB, ex_store_data, ex_pc, ex_imm;
  logic [OW-1:0] Operation;
  logic          ex_valid, ex_reg_write;
  logic [AW-1:0] ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the instruction currently held in EX.
  logic          m_valid, m_rw, m_src, m_f7;
  logic [1:0]    m_aluop;
  logic [2:0]    m_f3;
  logic [AW-1:0] m_rs1a, m_rs2a, m_rd;
  logic [DW-1:0] m_rs1d, m_rs2d, m_imm, m_pc;

  ex_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_imm(ex_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_src = 0; m_f7 = 0; m_aluop = 0; m_f3 = 0;
    m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_pc = 0;
  endtask

  // Applies the flush > stall > load rule to the model, then advances one edge.
  task automatic tick();
    if (flush) model_clear();
    else if (!stall) begin
      m_valid = id_valid; m_rw = id_reg_write; m_src = id_alu_src; m_f7 = id_funct7_b5;
      m_aluop = id_alu_op; m_f3 = id_funct3; m_rs1a = id_rs1_addr; m_rs2a = id_rs2_addr;
      m_rd = id_rd_addr; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm; m_pc = id_pc;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a == 0) return d;
    if (mem_reg_write && mem_rd == a) return mem_result;
    if (wb_reg_write && wb_rd == a) return wb_result;
    return d;
  endfunction

  function automatic logic [3:0] exp_op(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f7, input logic src);
    logic [3:0] branch_tab [8];
    logic [3:0] arith_tab [8];
    branch_tab = '{4'h8, 4'h5, 4'hF, 4'hF, 4'h6, 4'h7, 4'hF, 4'hF};
    arith_tab  = '{4'h2, 4'hF, 4'hF, 4'hF, 4'h3, 4'hF, 4'h1, 4'h0};
    if (op == 2'b00) return 4'h2;
    if (op == 2'b01) return branch_tab[f3];
    if (op == 2'b10) return (f3 == 0 && f7 && !src) ? 4'h4 : arith_tab[f3];
    return 4'hF;
  endfunction

  task automatic set_id(input logic v, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input logic [AW-1:0] rd, input logic [DW-1:0] imm, input logic [DW-1:0] pc,
                        input logic [1:0] op, input logic src, input logic [2:0] f3,
                        input logic f7, input logic rw);
    id_valid = v; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2; id_rs2_data = d2;
    id_rd_addr = rd; id_imm = imm; id_pc = pc; id_alu_op = op; id_alu_src = src;
    id_funct3 = f3; id_funct7_b5 = f7; id_reg_write = rw;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic test_reset();
    reset = 0; stall = 0; flush = 0; clear_fwd();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    model_clear();
    #12;
    for (int pass = 0; pass < 2; pass++) begin
      n_checks += 5;
      if (SrcA !== 0) begin n_fail++; $display("[TB] FAIL reset_srca pass%0d got %h want 0", pass, SrcA); end
      if (SrcB !== 0) begin n_fail++; $display("[TB] FAIL reset_srcb pass%0d got %h want 0", pass, SrcB); end
      if (Operation !== 4'b0010) begin n_fail++; $display("[TB] FAIL reset_op pass%0d got %b want 0010", pass, Operation); end
      if (ex_valid !== 0) begin n_fail++; $display("[TB] FAIL reset_valid pass%0d got %b want 0", pass, ex_valid); end
      if (ex_reg_write !== 0) begin n_fail++; $display("[TB] FAIL reset_rw pass%0d got %b want 0", pass, ex_reg_write); end
      if (pass == 0) begin
        @(negedge clk);
        reset = 1;
        tick();
      end
    end
  endtask

  task automatic test_rtype_sub();
    clear_fwd();
    set_id(1, 5, 20, 6, 7, 9, 32'd123, 32'h100, 2'b10, 0, 3'b000, 1, 1);
    tick();
    n_checks += 7;
    if (SrcA !== 20) begin n_fail++; $display("[TB] FAIL sub_srca got %0d want 20", SrcA); end
    if (SrcB !== 7) begin n_fail++; $display("[TB] FAIL sub_srcb got %0d want 7", SrcB); end
    if (Operation !== 4'b0100) begin n_fail++; $display("[TB] FAIL sub_op got %b want 0100", Operation); end
    if (ex_valid !== 1) begin n_fail++; $display("[TB] FAIL sub_valid got %b want 1", ex_valid); end
    if (ex_reg_write !== 1) begin n_fail++; $display("[TB] FAIL sub_rw got %b want 1", ex_reg_write); end
    if (ex_rd !== 9) begin n_fail++; $display("[TB] FAIL sub_rd got %0d want 9", ex_rd); end
    if (ex_pc !== 32'h100) begin n_fail++; $display("[TB] FAIL sub_pc got %h want 100", ex_pc); end
  endtask

  task automatic test_addi();
    clear_fwd();
    set_id(1, 5, 20, 6, 7, 9, 32'hFFFF_FFFD, 32'h104, 2'b10, 1, 3'b000, 1, 1);
    tick();
    n_checks += 5;
    if (Operation !== 4'b0010) begin n_fail++; $display("[TB] FAIL addi_op got %b want 0010", Operation); end
    if (SrcB !== 32'hFFFF_FFFD) begin n_fail++; $display("[TB] FAIL addi_srcb got %h want fffffffd", SrcB); end
    if (SrcA !== 20) begin n_fail++; $display("[TB] FAIL addi_srca got %0d want 20", SrcA); end
    if (ex_store_data !== 7) begin n_fail++; $display("[TB] FAIL addi_store got %0d want 7", ex_store_data); end
    if (ex_imm !== 32'hFFFF_FFFD) begin n_fail++; $display("[TB] FAIL addi_imm got %h want fffffffd", ex_imm); end
  endtask

  task automatic test_forward_priority();
    clear_fwd();
    set_id(1, 3, 32'h11, 4, 32'h22, 7, 0, 0, 2'b10, 0, 3'b000, 0, 1);
    tick();
    mem_reg_write = 1; mem_rd = 3; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 3; wb_result = 32'hBB;
    #1;
    n_checks += 2;
    if (SrcA !== 32'hAA) begin n_fail++; $display("[TB] FAIL fwd_mem_prio got %h want aa", SrcA); end
    if (SrcB !== 32'h22) begin n_fail++; $display("[TB] FAIL fwd_rs2_unrelated got %h want 22", SrcB); end
    mem_reg_write = 0;
    #1;
    n_checks++;
    if (SrcA !== 32'hBB) begin n_fail++; $display("[TB] FAIL fwd_wb got %h want bb", SrcA); end
    wb_reg_write = 0; mem_reg_write = 1; mem_rd = 4; mem_result = 32'hCC;
    #1;
    n_checks += 3;
    if (SrcA !== 32'h11) begin n_fail++; $display("[TB] FAIL fwd_none got %h want 11", SrcA); end
    if (SrcB !== 32'hCC) begin n_fail++; $display("[TB] FAIL fwd_srcb got %h want cc", SrcB); end
    if (ex_store_data !== 32'hCC) begin n_fail++; $display("[TB] FAIL fwd_store got %h want cc", ex_store_data); end
    set_id(1, 0, 32'h55, 0, 32'h66, 1, 0, 0, 2'b10, 0, 3'b000, 0, 1);
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'hBB;
    tick();
    n_checks += 2;
    if (SrcA !== 32'h55) begin n_fail++; $display("[TB] FAIL fwd_x0_rs1 got %h want 55", SrcA); end
    if (ex_store_data !== 32'h66) begin n_fail++; $display("[TB] FAIL fwd_x0_rs2 got %h want 66", ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_branch_decode();
    logic [2:0] f3s [5];
    logic [3:0] ops [5];
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
    ops = '{4'b1000, 4'b0101, 4'b0110, 4'b0111, 4'b1111};
    clear_fwd();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 1, 0, 2, 0, 0, 32'h40, 32'h200, 2'b01, 0, f3s[i], 0, 0);
      tick();
      n_checks += 2;
      if (Operation !== ops[i]) begin n_fail++; $display("[TB] FAIL branch_op f3=%b got %b want %b", f3s[i], Operation, ops[i]); end
      if (ex_reg_write !== 0) begin n_fail++; $display("[TB] FAIL branch_rw f3=%b got %b want 0", f3s[i], ex_reg_write); end
    end
  endtask

  task automatic test_stall_flush();
    clear_fwd();
    set_id(1, 5, 20, 6, 7, 9, 0, 32'h300, 2'b10, 0, 3'b000, 1, 1);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 10 + i, $urandom, 12 + i, $urandom, 20 + i, $urandom, $urandom, 2'b10, 1, 3'b111, 0, 0);
      tick();
      n_checks += 5;
      if (SrcA !== 20) begin n_fail++; $display("[TB] FAIL stall_srca cyc%0d got %0d want 20", i, SrcA); end
      if (SrcB !== 7) begin n_fail++; $display("[TB] FAIL stall_srcb cyc%0d got %0d want 7", i, SrcB); end
      if (Operation !== 4'b0100) begin n_fail++; $display("[TB] FAIL stall_op cyc%0d got %b want 0100", i, Operation); end
      if (ex_rd !== 9) begin n_fail++; $display("[TB] FAIL stall_rd cyc%0d got %0d want 9", i, ex_rd); end
      if (ex_pc !== 32'h300) begin n_fail++; $display("[TB] FAIL stall_pc cyc%0d got %h want 300", i, ex_pc); end
    end
    flush = 1;
    tick();
    n_checks += 4;
    if (ex_valid !== 0) begin n_fail++; $display("[TB] FAIL flush_valid got %b want 0", ex_valid); end
    if (ex_reg_write !== 0) begin n_fail++; $display("[TB] FAIL flush_rw got %b want 0", ex_reg_write); end
    if (Operation !== 4'b0010) begin n_fail++; $display("[TB] FAIL flush_op got %b want 0010", Operation); end
    if (ex_rd !== 0) begin n_fail++; $display("[TB] FAIL flush_rd got %0d want 0", ex_rd); end
    stall = 0; flush = 0;
  endtask

  task automatic test_reset_mid_stall();
    clear_fwd();
    set_id(1, 2, 32'h1234, 3, 32'h5678, 4, 32'h9, 32'h400, 2'b10, 0, 3'b110, 0, 1);
    tick();
    stall = 1;
    tick();
    #2;
    reset = 0;
    #1;
    model_clear();
    n_checks += 4;
    if (SrcA !== 0) begin n_fail++; $display("[TB] FAIL rststall_srca got %h want 0", SrcA); end
    if (SrcB !== 0) begin n_fail++; $display("[TB] FAIL rststall_srcb got %h want 0", SrcB); end
    if (ex_valid !== 0) begin n_fail++; $display("[TB] FAIL rststall_valid got %b want 0", ex_valid); end
    if (Operation !== 4'b0010) begin n_fail++; $display("[TB] FAIL rststall_op got %b want 0010", Operation); end
    @(negedge clk);
    reset = 1; stall = 0;
    tick();
    n_checks += 3;
    if (SrcA !== 32'h1234) begin n_fail++; $display("[TB] FAIL rststall_reload_srca got %h want 1234", SrcA); end
    if (ex_valid !== 1) begin n_fail++; $display("[TB] FAIL rststall_reload_valid got %b want 1", ex_valid); end
    if (Operation !== 4'b0001) begin n_fail++; $display("[TB] FAIL rststall_reload_op got %b want 0001", Operation); end
  endtask

  task automatic randomize_fwd();
    mem_reg_write = 1'($urandom); mem_rd = AW'($urandom_range(0, 7)); mem_result = $urandom;
    wb_reg_write = 1'($urandom); wb_rd = AW'($urandom_range(0, 7)); wb_result = $urandom;
  endtask

  task automatic test_random();
    logic [DW-1:0] e_a, e_b2, e_b;
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_id(1'($urandom), AW'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, 7)), $urandom,
             AW'($urandom_range(0, 7)), $urandom, $urandom, 2'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom));
      randomize_fwd();
      tick();
      for (int k = 0; k < 2; k++) begin
        e_a  = fwd(m_rs1a, m_rs1d);
        e_b2 = fwd(m_rs2a, m_rs2d);
        e_b  = m_src ? m_imm : e_b2;
        n_checks += 9;
        if (SrcA !== e_a) begin n_fail++; $display("[TB] FAIL rnd_srca it%0d got %h want %h", i, SrcA, e_a); end
        if (SrcB !== e_b) begin n_fail++; $display("[TB] FAIL rnd_srcb it%0d got %h want %h", i, SrcB, e_b); end
        if (ex_store_data !== e_b2) begin n_fail++; $display("[TB] FAIL rnd_store it%0d got %h want %h", i, ex_store_data, e_b2); end
        if (Operation !== exp_op(m_aluop, m_f3, m_f7, m_src)) begin
          n_fail++; $display("[TB] FAIL rnd_op it%0d got %b want %b", i, Operation, exp_op(m_aluop, m_f3, m_f7, m_src));
        end
        if (ex_valid !== m_valid) begin n_fail++; $display("[TB] FAIL rnd_valid it%0d got %b want %b", i, ex_valid, m_valid); end
        if (ex_reg_write !== (m_rw && m_valid)) begin n_fail++; $display("[TB] FAIL rnd_rw it%0d got %b want %b", i, ex_reg_write, m_rw && m_valid); end
        if (ex_rd !== m_rd) begin n_fail++; $display("[TB] FAIL rnd_rd it%0d got %0d want %0d", i, ex_rd, m_rd); end
        if (ex_pc !== m_pc) begin n_fail++; $display("[TB] FAIL rnd_pc it%0d got %h want %h", i, ex_pc, m_pc); end
        if (ex_imm !== m_imm) begin n_fail++; $display("[TB] FAIL rnd_imm it%0d got %h want %h", i, ex_imm, m_imm); end
        if (k == 0) begin
          randomize_fwd();
          #1;
        end
      end
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_addi();
    test_forward_priority();
    test_branch_decode();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand front end.
- Captures decoded-instruction fields from ID, applies MEM/WB forwarding, and selects SrcB from register or immediate.
- Decodes the 4-bit ALU Operation code and drives SrcA, SrcB and Operation directly into the EX-stage ALU.
- Carries the destination and write-enable fields forward to EX/MEM.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register index width.
- OPCODE_LENGTH, 4, width of the ALU Operation code.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold all pipeline registers.
- flush  in  1  insert a bubble at the next edge.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_pc  in  DATA_WIDTH  instruction PC.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_WIDTH  register indices.
- id_alu_op  in  2  00 = mem address, 01 = branch, 10 = arith, 11 = reserved.
- id_alu_src  in  1  1 = SrcB from immediate; 0 = register (R-type).
- id_funct3  in  3  instruction funct3.
- id_funct7_b5  in  1  instruction bit 30.
- id_reg_write  in  1  instruction writes rd.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_rd  in  REG_ADDR_WIDTH  MEM-stage destination index.
- mem_result  in  DATA_WIDTH  MEM-stage result.
- wb_reg_write  in  1  WB-stage write enable.
- wb_rd  in  REG_ADDR_WIDTH  WB-stage destination index.
- wb_result  in  DATA_WIDTH  WB-stage result.
- SrcA, SrcB  out  DATA_WIDTH  ALU operands.
- Operation  out  OPCODE_LENGTH  ALU operation code.
- ex_valid  out  1  EX holds a real instruction.
- ex_reg_write  out  1  registered id_reg_write AND ex_valid.
- ex_rd  out  REG_ADDR_WIDTH  registered destination index.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value, used by stores.
- ex_pc, ex_imm  out  DATA_WIDTH  registered PC and immediate, for the branch target.

Behaviour:
- Reset (asynchronous, reset=0): every pipeline register clears to 0.
  - ex_valid=0, ex_reg_write=0, ex_rd=0, SrcA=0, SrcB=0.
  - Operation=0010 (ADD, because registered alu_op=00).
- Register update priority at each rising edge: flush > stall > load.
  - flush=1: all fields load 0, producing a bubble (valid=0, alu_op=00, rs/rd addresses 0). Applies even when stall=1.
  - stall=1, flush=0: all registers hold their value.
  - Otherwise: all id_* fields load; ex_valid<=id_valid.
- Latency: one cycle from ID inputs to EX outputs. Forwarding and decode are combinational from the registered fields plus the current mem_*/wb_* inputs.
- Forwarding, applied separately to rs1 and rs2 using the registered addresses:
  - Forward from MEM if mem_reg_write=1, mem_rd!=0 and mem_rd==rsX.
  - Else forward from WB if wb_reg_write=1, wb_rd!=0 and wb_rd==rsX.
  - Else use the registered register-file data.
  - MEM has priority over WB.
  - Index x0 is never forwarded; rsX=0 always uses the registered data.
- Operand outputs:
  - SrcA = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - SrcB = alu_src ? registered imm : forwarded rs2.
- Operation decode (registered alu_op, funct3, funct7_b5, alu_src):
  - alu_op=00: 0010 ADD.
  - alu_op=01, by funct3: 000 gives 1000 BEQ; 001 gives 0101 BNE; 100 gives 0110 BLT; 101 gives 0111 BGE; all others give 1111.
  - alu_op=10, by funct3:
    - 000 gives 0100 SUB when alu_src=0 and funct7_b5=1; otherwise 0010 ADD. ADDI ignores bit 30.
    - 100 gives 0011 XOR; 110 gives 0001 OR; 111 gives 0000 AND.
    - All others give 1111.
  - alu_op=11: 1111.
  - Code 1111 is the unsupported marker; the ALU returns 0 for it.
- ex_reg_write = registered reg_write AND ex_valid, so a bubble never writes.
- Stall with changing mem_*/wb_* inputs: the registered fields hold, but the forwarded values re-evaluate every cycle.
- Reset asserted mid-stall or mid-flush: all registers clear immediately. After release, the first rising edge loads normally.

Test Plan:
- Reset check: reset=0, then release with id_valid=0 → SrcA=0, SrcB=0, Operation=0010, ex_valid=0, ex_reg_write=0.
- R-type SUB: rs1=x5 (data 20), rs2=x6 (data 7), alu_op=10, funct3=000, funct7_b5=1, alu_src=0 → next cycle SrcA=20, SrcB=7, Operation=0100.
- ADDI vs SUB: same fields with alu_src=1, imm=-3 → Operation=0010, SrcB=0xFFFFFFFD.
- Forward priority: rs1=x3; MEM writes x3=0xAA and WB writes x3=0xBB in the same cycle → SrcA=0xAA. Drop MEM → SrcA=0xBB. Set rs1=x0 with mem_rd=0 → registered data used.
- Branch decode: alu_op=01 with funct3 000, 001, 100, 101, 010 → Operation 1000, 0101, 0110, 0111, 1111.
- Stall/flush:
  - Load an instruction, then stall=1 for 3 cycles with new id_* inputs → EX fields unchanged.
  - stall=1 and flush=1 together → next cycle ex_valid=0, ex_reg_write=0.
  - Assert reset mid-stall → outputs clear asynchronously, before the next edge.
